// File: rtl/mips_data_mem_responder.sv
// Data-memory responder for the pipelined MIPS core's load/store port.
// Accepts one word request at a time, waits WAIT_CYCLES, then performs a
// byte-enabled store or full-word load on an internal RAM and holds the
// response until the core takes it. Bad addresses get an immediate error
// response and never reach the RAM.
module mips_data_mem_responder #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Misaligned, below the segment, or past its last word. The below-base
  // test guards the subtraction so the offset never wraps.
  function automatic logic addr_bad(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ((off >> 2) >= 32'(DEPTH));
  endfunction

  // Word index inside the RAM for an address already known to be in range.
  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0]      mem [DEPTH];
  state_t           state, next_state;
  logic [3:0]       cnt;
  logic             write_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [31:0]      wdata_p0;
  logic [3:0]       be_p0;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic             accept;
  logic             req_bad;
  logic             acc_fire;
  logic             acc_write;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_be;

  assign accept  = req_valid && (state == IDLE);
  assign req_bad = addr_bad(req_addr);

  // Select the access source: captured request at the end of WAIT, or the
  // live request at the accept edge when there are no wait states.
  always_comb begin
    acc_fire  = 1'b0;
    acc_write = write_p0;
    acc_idx   = idx_p0;
    acc_wdata = wdata_p0;
    acc_be    = be_p0;
    if (state == WAIT && cnt == 4'd0) begin
      acc_fire = 1'b1;
    end else if (WAIT_CYCLES == 0 && accept && !req_bad) begin
      acc_fire  = 1'b1;
      acc_write = req_write;
      acc_idx   = addr_idx(req_addr);
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  // Next-state logic for the request/wait/response sequence.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (accept) next_state = (req_bad || WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd0) next_state = RESP;
      RESP: if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register; reset drops any in-flight request so a pending store
  // can never reach the RAM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Wait counter and registered response word/error flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept && !req_bad && WAIT_CYCLES != 0) cnt <= WAIT_LOAD;
      else if (state == WAIT && cnt != 4'd0)      cnt <= cnt - 4'd1;

      if (accept && req_bad) begin
        err_q   <= 1'b1;
        rdata_q <= 32'd0;
      end else if (acc_fire) begin
        err_q   <= 1'b0;
        rdata_q <= acc_write ? 32'd0 : mem[acc_idx];
      end else if (state == RESP && rsp_ready) begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  // Capture the request payload at the accept edge.
  always_ff @(posedge clock) begin
    if (accept) begin
      write_p0 <= req_write;
      idx_p0   <= addr_idx(req_addr);
      wdata_p0 <= req_wdata;
      be_p0    <= req_be;
    end
  end

  // RAM write port: only the enabled byte lanes change.
  always_ff @(posedge clock) begin
    if (acc_fire && acc_write) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Directed bench for mips_data_mem_responder: one instance with two wait
// states and one with none, sharing clock, reset and request payload.
module tb_mips_data_mem_responder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        write;
  logic [31:0] addr, wdata;
  logic [3:0]  be;

  logic        valid2, ready2, rv2, rr2, err2;
  logic [31:0] rd2;
  logic        valid0, ready0, rv0, rr0, err0;
  logic [31:0] rd0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mips_data_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h1001_0000), .WAIT_CYCLES(2)) u_dut2 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(valid2), .req_ready(ready2), .req_write(write), .req_addr(addr),
    .req_wdata(wdata), .req_be(be),
    .rsp_valid(rv2), .rsp_ready(rr2), .rsp_rdata(rd2), .rsp_err(err2)
  );

  mips_data_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h1001_0000), .WAIT_CYCLES(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(valid0), .req_ready(ready0), .req_write(write), .req_addr(addr),
    .req_wdata(wdata), .req_be(be),
    .rsp_valid(rv0), .rsp_ready(rr0), .rsp_rdata(rd0), .rsp_err(err0)
  );

  // Drive one request into the selected instance (sel=1 -> zero-wait one),
  // then wait for its response. lat counts clock edges from accept (1 = the
  // accept edge itself) to the edge after which rsp_valid is seen.
  task automatic issue(input bit sel, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       output logic [31:0] rd, output logic er, output int lat, output bit ok);
    @(negedge clock);
    write = wr; addr = a; wdata = d; be = b;
    if (sel) valid0 = 1'b1; else valid2 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    valid0 = 1'b0; valid2 = 1'b0;
    write = 1'b1; addr = 32'hFFFF_FFFF; wdata = 32'h0BAD_0BAD; be = 4'hF;
    lat = 1; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((sel ? rv0 : rv2) === 1'b1) begin ok = 1'b1; break; end
      @(negedge clock);
      lat++;
    end
    rd = sel ? rd0 : rd2;
    er = sel ? err0 : err2;
  endtask

  // Complete the response handshake for the selected instance.
  task automatic done(input bit sel);
    if (sel) rr0 = 1'b1; else rr2 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rr0 = 1'b0; rr2 = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; valid2 = 1'b0; valid0 = 1'b0; rr2 = 1'b0; rr0 = 1'b0;
    write = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
    #12;
    n_checks++;
    if ({ready2, rv2, err2, rd2} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL rst_in_w2: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0", ready2, rv2, err2, rd2);
    end
    n_checks++;
    if ({ready0, rv0, err0, rd0} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL rst_in_w0: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0", ready0, rv0, err0, rd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({ready2, rv2, err2, rd2} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL rst_after: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0", ready2, rv2, err2, rd2);
    end
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic er; int lat; bit ok;
    issue(0, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF, 4'hF, rd, er, lat, ok);
    n_checks++;
    if (!ok || lat !== 3) begin n_fail++; $display("FAIL st_lat: got ok=%b lat=%0d want 3", ok, lat); end
    n_checks++;
    if ({er, rd} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL st_rsp: got err=%b rd=%h want 0 0", er, rd); end
    done(0);
    n_checks++;
    if ({ready2, rv2, err2, rd2} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL st_handshake: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0", ready2, rv2, err2, rd2);
    end
    issue(0, 1'b0, 32'h1001_0000, 32'd0, 4'h0, rd, er, lat, ok);
    n_checks++;
    if (!ok || lat !== 3) begin n_fail++; $display("FAIL ld_lat: got ok=%b lat=%0d want 3", ok, lat); end
    n_checks++;
    if ({er, rd} !== {1'b0, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL ld_data: got err=%b rd=%h want 0 deadbeef", er, rd); end
    done(0);
  endtask

  task automatic test_byte_enable;
    logic [31:0] rd; logic er; int lat; bit ok;
    issue(0, 1'b1, 32'h1001_0000, 32'h0000_0055, 4'b0001, rd, er, lat, ok);
    done(0);
    issue(0, 1'b0, 32'h1001_0000, 32'd0, 4'h0, rd, er, lat, ok);
    n_checks++;
    if ({ok, er, rd} !== {1'b1, 1'b0, 32'hDEAD_BE55}) begin n_fail++; $display("FAIL be_lane0: got err=%b rd=%h want 0 deadbe55", er, rd); end
    done(0);
    issue(0, 1'b1, 32'h1001_0000, 32'hFFFF_FFFF, 4'b0000, rd, er, lat, ok);
    n_checks++;
    if ({ok, er, rd} !== {1'b1, 1'b0, 32'd0}) begin n_fail++; $display("FAIL be_zero_rsp: got err=%b rd=%h want 0 0", er, rd); end
    done(0);
    issue(0, 1'b0, 32'h1001_0000, 32'd0, 4'h0, rd, er, lat, ok);
    n_checks++;
    if ({ok, rd} !== {1'b1, 32'hDEAD_BE55}) begin n_fail++; $display("FAIL be_zero_ram: got rd=%h want deadbe55", rd); end
    done(0);
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat; bit ok;
    logic        t_wr  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] t_adr [6] = '{32'h1001_0002, 32'h1001_0002, 32'h1000_FFFC,
                               32'h1001_1000, 32'h1001_0FFC, 32'hFFFF_FFFC};
    logic        t_err [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      issue(0, t_wr[i], t_adr[i], 32'h0000_0000, 4'hF, rd, er, lat, ok);
      n_checks++;
      if (!ok || er !== t_err[i] || rd !== 32'd0 || lat !== (t_err[i] ? 1 : 3)) begin
        n_fail++;
        $display("FAIL err_case%0d: addr=%h got err=%b rd=%h lat=%0d want err=%b rd=0 lat=%0d",
                 i, t_adr[i], er, rd, lat, t_err[i], t_err[i] ? 1 : 3);
      end
      done(0);
    end
    issue(0, 1'b0, 32'h1001_0000, 32'd0, 4'h0, rd, er, lat, ok);
    n_checks++;
    if ({ok, er, rd} !== {1'b1, 1'b0, 32'hDEAD_BE55}) begin n_fail++; $display("FAIL err_ram_kept: got err=%b rd=%h want 0 deadbe55", er, rd); end
    done(0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic er; int lat; bit ok;
    issue(0, 1'b1, 32'h1001_0004, 32'hA5A5_1234, 4'hF, rd, er, lat, ok);
    done(0);
    issue(0, 1'b0, 32'h1001_0004, 32'd0, 4'h0, rd, er, lat, ok);
    n_checks++;
    if ({ok, rd} !== {1'b1, 32'hA5A5_1234}) begin n_fail++; $display("FAIL b2b_first: got rd=%h want a5a51234", rd); end
    write = 1'b0; addr = 32'h1001_0000; be = 4'h0; valid2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_checks++;
      if ({rv2, ready2, err2, rd2} !== {1'b1, 1'b0, 1'b0, 32'hA5A5_1234}) begin
        n_fail++; $display("FAIL b2b_hold%0d: got vld=%b rdy=%b err=%b rd=%h want 1 0 0 a5a51234", i, rv2, ready2, err2, rd2);
      end
    end
    done(0);
    n_checks++;
    if ({ready2, rv2} !== 2'b10) begin n_fail++; $display("FAIL b2b_not_early: got rdy=%b vld=%b want 1 0", ready2, rv2); end
    @(posedge clock);
    @(negedge clock);
    valid2 = 1'b0; addr = 32'hFFFF_FFFF;
    n_checks++;
    if (ready2 !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: got rdy=%b want 0", ready2); end
    lat = 1; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rv2 === 1'b1) begin ok = 1'b1; break; end
      @(negedge clock);
      lat++;
    end
    n_checks++;
    if (!ok || lat !== 3 || rd2 !== 32'hDEAD_BE55) begin
      n_fail++; $display("FAIL b2b_second: got ok=%b lat=%0d rd=%h want lat=3 rd=deadbe55", ok, lat, rd2);
    end
    done(0);
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int lat; bit ok;
    issue(0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 4'hF, rd, er, lat, ok);
    done(0);
    @(negedge clock);
    write = 1'b1; addr = 32'h1001_0008; wdata = 32'h1234_5678; be = 4'hF; valid2 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    valid2 = 1'b0;
    n_checks++;
    if (ready2 !== 1'b0) begin n_fail++; $display("FAIL rm_in_wait: got rdy=%b want 0", ready2); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({ready2, rv2, err2, rd2} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL rm_async: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0", ready2, rv2, err2, rd2);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    issue(0, 1'b0, 32'h1001_0008, 32'd0, 4'h0, rd, er, lat, ok);
    n_checks++;
    if ({ok, er, rd} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL rm_ram_kept: got err=%b rd=%h want 0 deadbeef", er, rd); end
    done(0);
  endtask

  task automatic test_zero_wait;
    logic [31:0] rd; logic er; int lat; bit ok;
    issue(1, 1'b1, 32'h1001_0FFC, 32'hCAFE_F00D, 4'hF, rd, er, lat, ok);
    n_checks++;
    if (!ok || lat !== 1 || {er, rd} !== {1'b0, 32'd0}) begin
      n_fail++; $display("FAIL zw_store: got ok=%b lat=%0d err=%b rd=%h want lat=1 0 0", ok, lat, er, rd);
    end
    done(1);
    issue(1, 1'b0, 32'h1001_0FFC, 32'd0, 4'h0, rd, er, lat, ok);
    n_checks++;
    if (!ok || lat !== 1 || {er, rd} !== {1'b0, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL zw_load: got ok=%b lat=%0d err=%b rd=%h want lat=1 0 cafef00d", ok, lat, er, rd);
    end
    done(1);
    issue(1, 1'b0, 32'h1001_1000, 32'd0, 4'h0, rd, er, lat, ok);
    n_checks++;
    if (!ok || lat !== 1 || {er, rd} !== {1'b1, 32'd0}) begin
      n_fail++; $display("FAIL zw_range: got ok=%b lat=%0d err=%b rd=%h want lat=1 1 0", ok, lat, er, rd);
    end
    done(1);
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_byte_enable;
    test_errors;
    test_back_to_back;
    test_reset_mid;
    test_zero_wait;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
